sm_1118_status_tx: RTL
======================

SM_1118_STATUS_TX -- requirements
Module: sm_1118_status_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 clk  input  1  50 MHz system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 tx_start  input  1  level request from the status-update block; held high until tx_done seen.
REQ-005 su_msgtype  input  2  message type: 0 none, 1 status, 2 finish, 3 error.
REQ-006 su_sino  input  2  status-identification number (0-3).
REQ-007 su_color  input  2  color code: 0 none, 1 red, 2 green, 3 blue.
REQ-008 su_farm  input  2  farm number (0-3).
REQ-009 tx  output  1  UART serial line, 8 data bits, LSB first, idle high, registered.
REQ-010 tx_done  output  1  message-complete acknowledge.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 States SHALL be IDLE, LOAD, START, DATA, PARITY (macro only), STOP, NEXT, DONE.
REQ-013 In IDLE with tx_start=1, su_* SHALL be latched in the same edge; later su_* changes are ignored until IDLE returns.
REQ-014 Message type 1 SHALL be 10 bytes: 'S','I','-',0x30+sino,'-',C,'-',0x30+farm,'-','#'.
REQ-015 C SHALL be 'N'(0x4E), 'R'(0x52), 'G'(0x47), 'B'(0x42) for color 0..3.
REQ-016 Type 2 SHALL be "FIN-#" (5 bytes); type 3 SHALL be "ERR-#" (5 bytes).
REQ-017 Type 0 SHALL send no bytes: tx stays high, FSM goes IDLE->DONE directly.
REQ-018 Byte index counter SHALL be 4 bits, reset to 0 in LOAD; NEXT increments and returns to START until index equals length-1.
REQ-019 tx SHALL go low (start bit) exactly 2 cycles after tx_start is sampled high in IDLE (IDLE->LOAD->START).
REQ-020 Every bit (start, data, parity, stop) SHALL last exactly CLKS_PER_BIT cycles; baud counter reloads at each bit boundary.
REQ-021 Bytes SHALL be back-to-back: next start bit follows the last stop-bit cycle with at most 1 cycle of idle high (NEXT).
REQ-022 tx_done SHALL rise on the cycle after the final stop bit ends and stay high while tx_start=1.
REQ-023 In DONE with tx_start=0, tx_done SHALL drop next cycle and FSM SHALL return to IDLE; a message is never repeated for one request.
REQ-024 tx_start deasserting mid-message SHALL NOT abort the message; DONE then lasts exactly 1 cycle.
REQ-025 tx_start high again while tx_done is high SHALL NOT start a new message until after the IDLE cycle.

Reset
REQ-026 On rst=1: state IDLE, tx=1, tx_done=0, busy=0, byte index=0, baud and bit counters=0, latched fields=0.
REQ-027 rst mid-frame SHALL force tx=1 on the next edge with no partial bits; rst has priority over tx_start.
REQ-028 tx_start=1 while rst deasserts SHALL start a fresh message, start bit 2 cycles after the first non-reset edge.

Configuration
REQ-029 Macro SM_TX_PARITY_EN defined: an even-parity bit (XOR of 8 data bits) SHALL follow bit 7, giving 11-bit frames.
REQ-030 Macro SM_TX_PARITY_EN undefined: no PARITY state; 10-bit 8N1 frames; all other timing identical.

Verification (bench uses CLKS_PER_BIT=4)
REQ-031 rst 3 cycles then release -> tx=1, tx_done=0, busy=0 continuously for 50 cycles.
REQ-032 tx_start=1, msgtype=1, sino=2, color=1, farm=3 -> decoded bytes "SI-2-R-3-#"; tx_done high after 10x40 bit-cycles plus at most 9 NEXT cycles.
REQ-033 msgtype=2 with tx_start held 100 cycles past tx_done -> "FIN-#" sent once; tx_done falls 1 cycle after tx_start=0.
REQ-034 msgtype=0, tx_start=1 -> tx never low; tx_done high by cycle 3.
REQ-035 msgtype=3 started, rst pulsed 1 cycle during byte 2 -> tx=1 next edge; with tx_start still high, "ERR-#" restarts from 'E'.
REQ-036 SM_TX_PARITY_EN defined, sino=1, color=3 -> byte '1' (0x31) parity bit 1, 'B' (0x42) parity bit 0; frame length 44 cycles.

Source files
------------

// File: rtl/sm_1118_status_tx_if.sv
// Status-transmit request/response bundle between the status-update block and the UART sender.
// master: status-update side (drives tx_start and su_* fields, observes tx/tx_done/busy).
// slave : UART sender side (samples the request, drives the serial line and status flags).
interface sm_1118_status_tx_if;
    logic       tx_start;    // level request, held until tx_done is seen
    logic [1:0] su_msgtype;  // 0 none, 1 status, 2 finish, 3 error
    logic [1:0] su_sino;     // status-identification number
    logic [1:0] su_color;    // 0 none, 1 red, 2 green, 3 blue
    logic [1:0] su_farm;     // farm number
    logic       tx;          // UART serial line, idle high
    logic       tx_done;     // message-complete acknowledge
    logic       busy;        // high whenever the sender is not idle

    modport master (
        output tx_start, su_msgtype, su_sino, su_color, su_farm,
        input  tx, tx_done, busy
    );

    modport slave (
        input  tx_start, su_msgtype, su_sino, su_color, su_farm,
        output tx, tx_done, busy
    );
endinterface

// File: rtl/sm_1118_status_tx.sv
// Purpose: formats a status/finish/error message from latched su_* fields and sends it as UART bytes.
// Latency: start bit appears 2 cycles after tx_start is sampled in IDLE; bytes are sent back-to-back.
// Backpressure: none on the line; tx_start is a level request acknowledged by tx_done (held while tx_start=1).
// Ports: clk, rst (synchronous, active-high), bus (sm_1118_status_tx_if.slave).
// Optional: define SM_TX_PARITY_EN to append an even-parity bit after data bit 7 (11-bit frames).
module sm_1118_status_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    sm_1118_status_tx_if.slave    bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef SM_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        NEXT,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [3:0]    byte_idx;
    logic [1:0]    msgtype_q, sino_q, color_q, farm_q;
    logic          tx_q, tx_done_q, busy_q;

    logic [3:0]    msg_len;
    logic [7:0]    cur_byte;
    logic [7:0]    color_chr;
    logic          bit_end;
    logic          last_byte;
    logic          tx_nxt;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign last_byte = (byte_idx == (msg_len - 4'd1));

    // Message table: the current byte is looked up from the latched fields and byte index.
    always_comb begin
        msg_len   = 4'd0;
        cur_byte  = 8'hFF;
        color_chr = 8'h4E;
        case (color_q)
            2'd1:    color_chr = 8'h52;
            2'd2:    color_chr = 8'h47;
            2'd3:    color_chr = 8'h42;
            default: color_chr = 8'h4E;
        endcase
        case (msgtype_q)
            2'd1: begin
                msg_len = 4'd10;
                case (byte_idx)
                    4'd0:    cur_byte = 8'h53;
                    4'd1:    cur_byte = 8'h49;
                    4'd3:    cur_byte = 8'h30 + {6'd0, sino_q};
                    4'd5:    cur_byte = color_chr;
                    4'd7:    cur_byte = 8'h30 + {6'd0, farm_q};
                    4'd9:    cur_byte = 8'h23;
                    default: cur_byte = 8'h2D;
                endcase
            end
            2'd2, 2'd3: begin
                msg_len = 4'd5;
                case (byte_idx)
                    4'd0:    cur_byte = (msgtype_q == 2'd2) ? 8'h46 : 8'h45;
                    4'd1:    cur_byte = (msgtype_q == 2'd2) ? 8'h49 : 8'h52;
                    4'd2:    cur_byte = (msgtype_q == 2'd2) ? 8'h4E : 8'h52;
                    4'd3:    cur_byte = 8'h2D;
                    default: cur_byte = 8'h23;
                endcase
            end
            default: begin
                msg_len  = 4'd0;
                cur_byte = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the line level for the current state; tx is registered from this,
    // so the line trails the state by one cycle and every bit still spans CLKS_PER_BIT cycles.
    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (bus.tx_start) begin
                    state_nxt = (bus.su_msgtype == 2'd0) ? DONE : LOAD;
                end
            end
            LOAD: state_nxt = START;
            START: begin
                tx_nxt = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                tx_nxt = cur_byte[bit_cnt];
                if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef SM_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef SM_TX_PARITY_EN
            PARITY: begin
                tx_nxt = ^cur_byte;
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) state_nxt = NEXT;
            end
            NEXT: state_nxt = last_byte ? DONE : START;
            DONE: begin
                if (!bus.tx_start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            busy_q    <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 4'd0;
            msgtype_q <= 2'd0;
            sino_q    <= 2'd0;
            color_q   <= 2'd0;
            farm_q    <= 2'd0;
        end else begin
            tx_q      <= tx_nxt;
            tx_done_q <= (state_nxt == DONE);
            busy_q    <= (state_nxt != IDLE);

            // Fields are captured only on the accepting edge so later su_* changes cannot corrupt the message.
            if ((state == IDLE) && bus.tx_start) begin
                msgtype_q <= bus.su_msgtype;
                sino_q    <= bus.su_sino;
                color_q   <= bus.su_color;
                farm_q    <= bus.su_farm;
            end

            if (state == LOAD) begin
                byte_idx <= 4'd0;
            end else if ((state == NEXT) && !last_byte) begin
                byte_idx <= byte_idx + 4'd1;
            end

            case (state)
                START, DATA,
`ifdef SM_TX_PARITY_EN
                PARITY,
`endif
                STOP:    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                default: baud_cnt <= '0;
            endcase

            if (state == START) begin
                bit_cnt <= 3'd0;
            end else if ((state == DATA) && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_done = tx_done_q;
    assign bus.busy    = busy_q;

endmodule
